maj_vote_pipe: RTL and testbench

MAJ_VOTE_PIPE -- requirements
Module: maj_vote_pipe

---
 rtl/maj_vote_pipe.sv | 105 ++++++++++
 tb/tb_maj_vote_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/maj_vote_pipe.sv
// N-lane bitwise majority voter with a one-deep output register and
// per-lane mismatch statistics (total count, consecutive count, sticky fault).
module maj_vote_pipe #(
  parameter int W      = 8,
  parameter int N      = 3,
  parameter int CNT_W  = 16,
  parameter int THRESH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W-1:0]     in_data,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic [N-1:0]       out_mismatch,
  output logic               out_agree,
  output logic [N-1:0]       fault,
  output logic [N*CNT_W-1:0] mis_cnt
);

  if ((N < 3) || (N > 7) || ((N % 2) == 0)) begin : g_bad_n
    $error("maj_vote_pipe: N must be odd and within 3..7");
  end
  if ((W < 1) || (W > 32)) begin : g_bad_w
    $error("maj_vote_pipe: W must be within 1..32");
  end
  if ((THRESH < 1) || ((CNT_W < 31) && (THRESH >= (1 << CNT_W)))) begin : g_bad_thresh
    $error("maj_vote_pipe: THRESH must be within 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic               in_xfer;
  logic [W-1:0]       vote;
  logic [N-1:0]       mism;
  logic [3:0]         ones;
  logic [N*CNT_W-1:0] tot_q;
  logic [N*CNT_W-1:0] cons_q;

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign mis_cnt  = tot_q;

  always_comb begin
    vote = '0;
    mism = '0;
    ones = '0;
    for (int b = 0; b < W; b++) begin
      ones = '0;
      for (int i = 0; i < N; i++) begin
        ones = ones + {3'b000, in_data[i*W+b]};
      end
      vote[b] = (ones > 4'(N / 2));
    end
    for (int i = 0; i < N; i++) begin
      mism[i] = (in_data[i*W +: W] != vote);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_mismatch <= '0;
      out_agree    <= 1'b0;
    end else if (in_xfer) begin
      out_valid    <= 1'b1;
      out_data     <= vote;
      out_mismatch <= mism;
      out_agree    <= ~|mism;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Statistics move only on accepted inputs; clear beats a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      fault  <= '0;
      tot_q  <= '0;
      cons_q <= '0;
    end else if (in_xfer) begin
      for (int i = 0; i < N; i++) begin
        if (mism[i]) begin
          if (tot_q[i*CNT_W +: CNT_W] != '1) begin
            tot_q[i*CNT_W +: CNT_W] <= tot_q[i*CNT_W +: CNT_W] + ONE;
          end
          if (cons_q[i*CNT_W +: CNT_W] != THR) begin
            cons_q[i*CNT_W +: CNT_W] <= cons_q[i*CNT_W +: CNT_W] + ONE;
          end
          if ((cons_q[i*CNT_W +: CNT_W] + ONE) == THR) begin
            fault[i] <= 1'b1;
          end
        end else begin
          cons_q[i*CNT_W +: CNT_W] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_maj_vote_pipe.sv
// Bench for maj_vote_pipe (W=8, N=3, CNT_W=16, THRESH=4): directed cases
// followed by random traffic, compared against a transaction-level model.
module tb_maj_vote_pipe;

  localparam int W      = 8;
  localparam int N      = 3;
  localparam int CNT_W  = 16;
  localparam int THRESH = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [N*W-1:0]     in_data;
  logic               clear;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_data;
  logic [N-1:0]       out_mismatch;
  logic               out_agree;
  logic [N-1:0]       fault;
  logic [N*CNT_W-1:0] mis_cnt;

  int compared = 0;
  int mismatched = 0;

  // reference model state
  logic         m_ov;
  logic [W-1:0] m_od;
  logic [N-1:0] m_mm;
  logic         m_ag;
  int           m_tot  [N];
  int           m_cons [N];
  logic [N-1:0] m_fault;

  maj_vote_pipe #(.W(W), .N(N), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mismatch(out_mismatch),
    .out_agree(out_agree), .fault(fault), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 1'b0; m_od = '0; m_mm = '0; m_ag = 1'b0; m_fault = '0;
    for (int l = 0; l < N; l++) begin
      m_tot[l] = 0;
      m_cons[l] = 0;
    end
  endtask

  // One clock edge of the block, described at the transaction level.
  task automatic model_edge(input logic rst, iv, input logic [N*W-1:0] d,
                            input logic clr, ordy);
    logic [W-1:0] lane [N];
    logic [W-1:0] v;
    logic [N-1:0] mm;
    logic         xfer;
    int           cnt;
    if (rst) begin
      model_reset();
      return;
    end
    for (int l = 0; l < N; l++) lane[l] = d[l*W +: W];
    v = '0;
    for (int b = 0; b < W; b++) begin
      cnt = 0;
      for (int l = 0; l < N; l++) cnt += int'(lane[l][b]);
      v[b] = (2 * cnt > N);
    end
    for (int l = 0; l < N; l++) mm[l] = (lane[l] != v);
    xfer = iv && (!m_ov || ordy);
    if (xfer) begin
      m_ov = 1'b1; m_od = v; m_mm = mm; m_ag = (mm == '0);
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (clr) begin
      m_fault = '0;
      for (int l = 0; l < N; l++) begin
        m_tot[l] = 0;
        m_cons[l] = 0;
      end
    end else if (xfer) begin
      for (int l = 0; l < N; l++) begin
        if (mm[l]) begin
          m_tot[l]  = (m_tot[l] < CMAX) ? m_tot[l] + 1 : CMAX;
          m_cons[l] = (m_cons[l] < THRESH) ? m_cons[l] + 1 : THRESH;
          if (m_cons[l] == THRESH) m_fault[l] = 1'b1;
        end else begin
          m_cons[l] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [N*CNT_W-1:0] p;
    for (int l = 0; l < N; l++) p[l*CNT_W +: CNT_W] = CNT_W'(m_tot[l]);
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_data", 64'(out_data), 64'(m_od));
    chk("out_mismatch", 64'(out_mismatch), 64'(m_mm));
    chk("out_agree", 64'(out_agree), 64'(m_ag));
    chk("fault", 64'(fault), 64'(m_fault));
    chk("mis_cnt", 64'(mis_cnt), 64'(p));
  endtask

  task automatic step(input logic rst, iv, input logic [N*W-1:0] d,
                      input logic clr, ordy);
    reset = rst; in_valid = iv; in_data = d; clear = clr; out_ready = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'(!m_ov || ordy));
    @(posedge clk);
    model_edge(rst, iv, d, clr, ordy);
    #1;
    check_all();
  endtask

  initial begin
    logic [W-1:0]   base;
    logic [N*W-1:0] d;
    model_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    step(1'b1, 1'b1, 24'h123456, 1'b1, 1'b0);
    chk("reset_out_valid", 64'(out_valid), 64'h0);

    // first cycle after reset: ready without any output handshake
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("post_reset_in_ready", 64'(in_ready), 64'h1);

    // all lanes agree
    step(1'b0, 1'b1, {8'hA5, 8'hA5, 8'hA5}, 1'b0, 1'b1);
    chk("agree_data", 64'(out_data), 64'hA5);
    chk("agree_flag", 64'(out_agree), 64'h1);
    chk("agree_mm", 64'(out_mismatch), 64'h0);
    chk("agree_cnt", 64'(mis_cnt), 64'h0);

    // lanes 0 and 1 lose the vote
    step(1'b0, 1'b1, {8'hFF, 8'h0F, 8'hF0}, 1'b0, 1'b1);
    chk("vote_data", 64'(out_data), 64'hFF);
    chk("vote_mm", 64'(out_mismatch), 64'b011);
    chk("vote_cnt", 64'(mis_cnt), 64'h0000_0001_0001);

    // lane 2 wrong four times in a row; no fault after the third
    for (int k = 0; k < THRESH; k++) begin
      step(1'b0, 1'b1, {8'h11, 8'h22, 8'h22}, 1'b0, 1'b1);
      if (k == THRESH - 2) chk("fault_before_thresh", 64'(fault), 64'b000);
    end
    chk("fault_at_thresh", 64'(fault), 64'b100);
    step(1'b0, 1'b1, {8'h33, 8'h33, 8'h33}, 1'b0, 1'b1);
    chk("fault_sticky", 64'(fault), 64'b100);
    chk("fault_cnt", 64'(mis_cnt), 64'h0004_0001_0001);
    step(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
    chk("clear_fault", 64'(fault), 64'b000);
    chk("clear_cnt", 64'(mis_cnt), 64'h0);

    // backpressure: held result, blocked input, then same-cycle accept
    step(1'b0, 1'b1, {8'h66, 8'h66, 8'h66}, 1'b0, 1'b0);
    step(1'b0, 1'b1, {8'h77, 8'h77, 8'h70}, 1'b0, 1'b0);
    chk("stall_data", 64'(out_data), 64'h66);
    chk("stall_cnt", 64'(mis_cnt), 64'h0);
    step(1'b0, 1'b1, {8'h77, 8'h77, 8'h70}, 1'b0, 1'b1);
    chk("release_data", 64'(out_data), 64'h77);
    chk("release_mm", 64'(out_mismatch), 64'b001);

    // clear wins over the counters of a same-cycle transfer
    step(1'b0, 1'b1, {8'h44, 8'h55, 8'h44}, 1'b1, 1'b1);
    chk("clear_xfer_mm", 64'(out_mismatch), 64'b010);
    chk("clear_xfer_cnt", 64'(mis_cnt), 64'h0);

    // lane 0 goes faulty, then reset with a result pending
    for (int k = 0; k < THRESH; k++) step(1'b0, 1'b1, {8'hAA, 8'hAA, 8'h55}, 1'b0, 1'b1);
    chk("lane0_fault", 64'(fault), 64'b001);
    step(1'b1, 1'b1, {8'h01, 8'h02, 8'h03}, 1'b0, 1'b0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_fault", 64'(fault), 64'h0);
    chk("rst_cnt", 64'(mis_cnt), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // random traffic; lane 2 is corrupted often enough to cross the threshold
    for (int n = 0; n < 400; n++) begin
      base = 8'($urandom);
      for (int l = 0; l < N; l++) begin
        d[l*W +: W] = base;
        if ($urandom_range(99, 0) < ((l == 2) ? 55 : 15))
          d[l*W +: W] = base ^ 8'($urandom_range(255, 1));
      end
      step(($urandom_range(199, 0) == 0), ($urandom_range(9, 0) < 8), d,
           ($urandom_range(39, 0) == 0), ($urandom_range(9, 0) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
